// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the FSM state encoding, default widths and the alignment helpers.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 64;
  localparam int DATA_W_DEF       = 64;
  localparam int MAX_D_STREAK_DEF = 4;
  localparam int STREAK_W         = 4;
  localparam int WORD_W           = 32;

  localparam logic [2:0] DW_ALIGN_MASK = 3'b111;
  localparam logic [1:0] W_ALIGN_MASK  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } arb_state_e;

  function automatic logic dw_misaligned(input logic [2:0] lsb);
    return (lsb & DW_ALIGN_MASK) != 3'b000;
  endfunction

  function automatic logic w_misaligned(input logic [1:0] lsb);
    return (lsb & W_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data grants made while a fetch is waiting.
// force_i tells the arbiter to give the next grant to the fetch port.
module arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_grant,
  input  logic i_grant,
  input  logic i_req,
  input  logic idle,
  output logic force_i
);

  localparam logic [STREAK_W-1:0] MAX_CNT = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] cnt_q;
  logic [STREAK_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_grant) begin
      cnt_d = '0;
    end else if (d_grant && i_req) begin
      if (cnt_q < MAX_CNT) cnt_d = cnt_q + 1'b1;
    end else if (idle && !i_req) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign force_i = (cnt_q >= MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-port memory,
// running one req/ack transaction at a time with data-port priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q,     i_ack_d;
  logic [WORD_W-1:0] i_rdata_q,   i_rdata_d;
  logic              i_err_q,     i_err_d;
  logic              i_sel_q,     i_sel_d;
  logic              d_ack_q,     d_ack_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              d_err_q,     d_err_d;

  logic d_grant;
  logic i_grant;
  logic force_i;
  logic idle;

  assign idle = (state_q == IDLE);

  arb_streak_ctr #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk    (clk),
    .rst    (rst),
    .d_grant(d_grant),
    .i_grant(i_grant),
    .i_req  (i_req),
    .idle   (idle),
    .force_i(force_i)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = i_ack_q;
    i_rdata_d   = i_rdata_q;
    i_err_d     = i_err_q;
    i_sel_d     = i_sel_q;
    d_ack_d     = d_ack_q;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    d_grant     = 1'b0;
    i_grant     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data wins unless a waiting fetch has been passed over too often.
        if (d_req && (!i_req || !force_i)) begin
          d_grant = 1'b1;
          if (dw_misaligned(d_addr[2:0])) begin
            state_d   = RESP_D;
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d     = BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = {d_addr[ADDR_W-1:3], 3'b000};
            mem_wdata_d = d_wdata;
          end
        end else if (i_req) begin
          i_grant = 1'b1;
          if (w_misaligned(i_addr[1:0])) begin
            state_d   = RESP_I;
            i_ack_d   = 1'b1;
            i_err_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            state_d     = BUSY_I;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {i_addr[ADDR_W-1:3], 3'b000};
            mem_wdata_d = '0;
            i_sel_d     = i_addr[2];
          end
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d   = RESP_I;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = i_sel_q ? mem_rdata[2*WORD_W-1:WORD_W] : mem_rdata[WORD_W-1:0];
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = RESP_D;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_ack_d   = 1'b1;
          // Stores return zero so the CPU never sees stale memory contents.
          d_rdata_d = mem_we_q ? '0 : mem_rdata;
        end
      end
      RESP_I: begin
        state_d   = IDLE;
        i_ack_d   = 1'b0;
        i_rdata_d = '0;
        i_err_d   = 1'b0;
      end
      RESP_D: begin
        state_d   = IDLE;
        d_ack_d   = 1'b0;
        d_rdata_d = '0;
        d_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      i_err_q     <= 1'b0;
      i_sel_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      i_err_q     <= i_err_d;
      i_sel_q     <= i_sel_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule
